// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-outstanding instruction fetch sequencer with redirect and drop handling
module fetch_sequencer #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   output logic             o_imem_req_valid,
   input  logic             i_imem_req_ready,
   output logic [XLEN-1:0]  o_imem_req_addr,
   input  logic             i_imem_rsp_valid,
   input  logic [31:0]      i_imem_rsp_data,
   output logic             o_instr_valid,
   input  logic             i_instr_ready,
   output logic [31:0]      o_instr_data,
   output logic [XLEN-1:0]  o_instr_pc,
   input  logic             i_redirect_valid,
   input  logic [XLEN-1:0]  i_redirect_pc,
   input  logic             i_stall,
   output logic             o_misaligned,
   output logic [XLEN-1:0]  o_retired_count
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [XLEN-1:0]   pc, pc_n;
   logic              drop, drop_n;
   // pending: request was offered but not yet taken, so it must stay up even if stall rises
   logic              pending, pending_n;
   // armed: keeps the first request off the bus until one full edge has passed out of reset
   logic              armed;
   logic              misaligned_q;
   logic [31:0]       data_q, data_n;
   logic [XLEN-1:0]   ipc_q, ipc_n;
   logic [XLEN-1:0]   count_q, count_n;
   logic [XLEN-1:0]   redirect_aligned;
   logic              req_fire;

   assign redirect_aligned = {i_redirect_pc[XLEN-1:2], 2'b00};
   assign o_imem_req_valid = (state == S_REQ) && armed && (!i_stall || pending);
   assign o_imem_req_addr  = pc;
   assign req_fire         = o_imem_req_valid && i_imem_req_ready;
   assign o_instr_valid    = (state == S_OUT);
   assign o_instr_data     = data_q;
   assign o_instr_pc       = ipc_q;
   assign o_misaligned     = misaligned_q;
   assign o_retired_count  = count_q;

   // Next-state, PC, drop flag and instruction capture; redirect always wins over handshakes
   always_comb begin
      state_n   = state;
      pc_n      = pc;
      drop_n    = drop;
      pending_n = pending;
      data_n    = data_q;
      ipc_n     = ipc_q;
      count_n   = count_q;
      case (state)
         S_REQ: begin
            pending_n = o_imem_req_valid && !i_imem_req_ready;
            if (req_fire) begin
               state_n = S_WAIT;
            end
            if (i_redirect_valid) begin
               pc_n = redirect_aligned;
               // the accepted request targets the old PC; its response must be thrown away
               if (req_fire) begin
                  drop_n = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (i_redirect_valid) begin
               pc_n = redirect_aligned;
               if (i_imem_rsp_valid) begin
                  drop_n  = 1'b0;
                  state_n = S_REQ;
               end else begin
                  drop_n = 1'b1;
               end
            end else if (i_imem_rsp_valid) begin
               if (drop) begin
                  drop_n  = 1'b0;
                  state_n = S_REQ;
               end else begin
                  data_n  = i_imem_rsp_data;
                  ipc_n   = pc;
                  state_n = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (i_redirect_valid) begin
               pc_n    = redirect_aligned;
               state_n = S_REQ;
            end else if (i_instr_ready) begin
               pc_n    = pc + XLEN'(4);
               count_n = count_q + XLEN'(1);
               state_n = S_REQ;
            end
         end
         default: begin
            state_n = S_REQ;
         end
      endcase
   end

   // State register and outputs; synchronous reset overrides every handshake and redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_REQ;
         pc           <= RESET_PC;
         drop         <= 1'b0;
         pending      <= 1'b0;
         armed        <= 1'b0;
         misaligned_q <= 1'b0;
         data_q       <= '0;
         ipc_q        <= '0;
         count_q      <= '0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         drop         <= drop_n;
         pending      <= pending_n;
         armed        <= 1'b1;
         misaligned_q <= i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
         data_q       <= data_n;
         ipc_q        <= ipc_n;
         count_q      <= count_n;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        stall;
   logic        misaligned;
   logic [31:0] retired;

   int n_cmp;
   int n_fail;

   fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .o_imem_req_valid (req_valid),
      .i_imem_req_ready (req_ready),
      .o_imem_req_addr  (req_addr),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .o_instr_valid    (instr_valid),
      .i_instr_ready    (instr_ready),
      .o_instr_data     (instr_data),
      .o_instr_pc       (instr_pc),
      .i_redirect_valid (redir_valid),
      .i_redirect_pc    (redir_pc),
      .i_stall          (stall),
      .o_misaligned     (misaligned),
      .o_retired_count  (retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      instr_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0; stall = 1'b0;
      step(); step();
      redir_valid = 1'b1; redir_pc = 32'h0000_0103; instr_ready = 1'b1; req_ready = 1'b1;
      step();
      redir_valid = 1'b0; redir_pc = '0; instr_ready = 1'b0; req_ready = 1'b0;
      #1;
      n_cmp++; if (req_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_req_valid got %b want 0", req_valid); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
      n_cmp++; if (misaligned !== 1'b0)  begin n_fail++; $display("FAIL rst_misaligned got %b want 0", misaligned); end
      n_cmp++; if (instr_data !== 32'h0) begin n_fail++; $display("FAIL rst_instr_data got %h want 0", instr_data); end
      n_cmp++; if (instr_pc !== 32'h0)   begin n_fail++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
      n_cmp++; if (retired !== 32'h0)    begin n_fail++; $display("FAIL rst_count got %h want 0", retired); end
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_early_req got %b want 0", req_valid); end
      step();
      n_cmp++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_first_req got %b want 1", req_valid); end
   endtask

   task automatic test_basic();
      for (int k = 0; k < 3; k++) begin
         req_ready = 1'b1;
         #1;
         n_cmp++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_req_valid[%0d] got %b want 1", k, req_valid); end
         n_cmp++; if (req_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL basic_addr[%0d] got %h want %h", k, req_addr, 32'(4 * k)); end
         n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_excl[%0d] got %b want 0", k, instr_valid); end
         step();
         req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hA000_0000 + 32'(k);
         #1;
         n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req[%0d] got %b want 0", k, req_valid); end
         step();
         rsp_valid = 1'b0; instr_ready = 1'b1;
         #1;
         n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ivalid[%0d] got %b want 1", k, instr_valid); end
         n_cmp++; if (instr_data !== 32'hA000_0000 + 32'(k)) begin n_fail++; $display("FAIL basic_idata[%0d] got %h want %h", k, instr_data, 32'hA000_0000 + 32'(k)); end
         n_cmp++; if (instr_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL basic_ipc[%0d] got %h want %h", k, instr_pc, 32'(4 * k)); end
         n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_req[%0d] got %b want 0", k, req_valid); end
         step();
         instr_ready = 1'b0;
         #1;
         n_cmp++; if (retired !== 32'(k + 1)) begin n_fail++; $display("FAIL basic_count[%0d] got %0d want %0d", k, retired, k + 1); end
      end
   endtask

   task automatic test_hold();
      req_ready = 1'b1;
      step();
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hB0B0_0001;
      step();
      rsp_valid = 1'b0; instr_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_ivalid[%0d] got %b want 1", c, instr_valid); end
         n_cmp++; if (instr_data !== 32'hB0B0_0001) begin n_fail++; $display("FAIL hold_idata[%0d] got %h want b0b00001", c, instr_data); end
         n_cmp++; if (instr_pc !== 32'h0000_000C) begin n_fail++; $display("FAIL hold_ipc[%0d] got %h want 0000000c", c, instr_pc); end
         n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got %b want 0", c, req_valid); end
         n_cmp++; if (retired !== 32'd3) begin n_fail++; $display("FAIL hold_count[%0d] got %0d want 3", c, retired); end
         step();
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      #1;
      n_cmp++; if (retired !== 32'd4) begin n_fail++; $display("FAIL hold_count_after got %0d want 4", retired); end
      n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h10) begin n_fail++; $display("FAIL hold_next_req got %b/%h want 1/00000010", req_valid, req_addr); end
   endtask

   task automatic test_redirect_wait();
      req_ready = 1'b1;
      step();
      req_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'h0000_0100;
      step();
      redir_valid = 1'b0; redir_pc = '0;
      #1;
      n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL rw_misaligned got %b want 0", misaligned); end
      n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_still_wait got %b want 0", req_valid); end
      step();
      rsp_valid = 1'b1; rsp_data = 32'hDEAD_0000;
      step();
      rsp_valid = 1'b0;
      #1;
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_dropped got %b want 0", instr_valid); end
      n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin n_fail++; $display("FAIL rw_next_req got %b/%h want 1/00000100", req_valid, req_addr); end
      req_ready = 1'b1;
      step();
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hC0DE_0100;
      step();
      rsp_valid = 1'b0;
      #1;
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin n_fail++; $display("FAIL rw_deliver got %b/%h want 1/00000100", instr_valid, instr_pc); end
      n_cmp++; if (instr_data !== 32'hC0DE_0100) begin n_fail++; $display("FAIL rw_data got %h want c0de0100", instr_data); end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      #1;
      n_cmp++; if (retired !== 32'd5) begin n_fail++; $display("FAIL rw_count got %0d want 5", retired); end
   endtask

   task automatic test_redirect_out();
      req_ready = 1'b1;
      step();
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h5555_0104;
      step();
      rsp_valid = 1'b0; instr_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h0000_0202;
      #1;
      n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ro_in_out got %b want 1", instr_valid); end
      step();
      instr_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
      #1;
      n_cmp++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL ro_misaligned got %b want 1", misaligned); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ro_discard got %b want 0", instr_valid); end
      n_cmp++; if (retired !== 32'd5) begin n_fail++; $display("FAIL ro_count got %0d want 5", retired); end
      n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h200) begin n_fail++; $display("FAIL ro_next_req got %b/%h want 1/00000200", req_valid, req_addr); end
      step();
      n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL ro_pulse_len got %b want 0", misaligned); end
   endtask

   task automatic test_stall();
      req_ready = 1'b1;
      step();
      req_ready = 1'b0; stall = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h7777_0200;
      step();
      rsp_valid = 1'b0; instr_ready = 1'b1;
      #1;
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin n_fail++; $display("FAIL st_out_unaffected got %b/%h want 1/00000200", instr_valid, instr_pc); end
      step();
      instr_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL st_inhibit[%0d] got %b want 0", c, req_valid); end
         step();
      end
      stall = 1'b0;
      #1;
      n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h204) begin n_fail++; $display("FAIL st_release got %b/%h want 1/00000204", req_valid, req_addr); end
      step();
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h204) begin n_fail++; $display("FAIL st_hold[%0d] got %b/%h want 1/00000204", c, req_valid, req_addr); end
         step();
      end
      stall = 1'b0; req_ready = 1'b1;
      step();
      req_ready = 1'b0;
   endtask

   task automatic test_reset_wait();
      rst = 1'b1;
      step();
      rsp_valid = 1'b1; rsp_data = 32'hBAD0_0000;
      step();
      rsp_valid = 1'b0;
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rwt_quiet got %b/%b want 0/0", req_valid, instr_valid); end
      n_cmp++; if (retired !== 32'd0) begin n_fail++; $display("FAIL rwt_count got %0d want 0", retired); end
      step();
      n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin n_fail++; $display("FAIL rwt_first_req got %b/%h want 1/00000000", req_valid, req_addr); end
      req_ready = 1'b1;
      step();
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
      step();
      rsp_valid = 1'b0;
      #1;
      n_cmp++; if (instr_data !== 32'h1234_5678 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL rwt_deliver got %h/%h want 12345678/00000000", instr_data, instr_pc); end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      #1;
      n_cmp++; if (retired !== 32'd1) begin n_fail++; $display("FAIL rwt_count_after got %0d want 1", retired); end
   endtask

   task automatic test_wrap();
      redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC; req_ready = 1'b0;
      step();
      redir_valid = 1'b0; redir_pc = '0;
      #1;
      n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_redirect_req got %b/%h want 1/fffffffc", req_valid, req_addr); end
      req_ready = 1'b1;
      step();
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hEEEE_FFFC;
      step();
      rsp_valid = 1'b0; instr_ready = 1'b1;
      #1;
      n_cmp++; if (instr_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_ipc got %h want fffffffc", instr_pc); end
      step();
      instr_ready = 1'b0;
      #1;
      n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %b/%h want 1/00000000", req_valid, req_addr); end
      n_cmp++; if (retired !== 32'd2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", retired); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_hold();
      test_redirect_wait();
      test_redirect_out();
      test_stall();
      test_reset_wait();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
